// File: rtl/vec_id_stage.sv
// Decode / register-read stage for the 64-bit vector datapath: owns the 32x64 register file,
// resolves operand hazards with per-byte EX/WB forwarding and feeds the ID/EX register.
module vec_id_stage #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [0:31] if_instr,
  input  logic        if_valid,
  input  logic [0:63] alu_out,
  input  logic        wb_en,
  input  logic [0:4]  wb_addr,
  input  logic [0:2]  wb_ppp,
  input  logic [0:63] wb_data,
  output logic        ex_valid,
  output logic [0:63] ex_rA_val,
  output logic [0:63] ex_rB_val,
  output logic [0:5]  ex_Op_code,
  output logic [0:5]  ex_R_ins,
  output logic [0:1]  ex_WW,
  output logic [0:4]  ex_rD,
  output logic [0:2]  ex_ppp,
  output logic        ex_reg_write
);

  typedef logic [0:63] word_t;

  word_t       rf_q [NREG];
  word_t       rf_d [NREG];

  logic        ex_valid_q,     ex_valid_d;
  word_t       ex_ra_val_q,    ex_ra_val_d;
  word_t       ex_rb_val_q,    ex_rb_val_d;
  logic [0:5]  ex_op_code_q,   ex_op_code_d;
  logic [0:5]  ex_r_ins_q,     ex_r_ins_d;
  logic [0:1]  ex_ww_q,        ex_ww_d;
  logic [0:4]  ex_rd_q,        ex_rd_d;
  logic [0:2]  ex_ppp_q,       ex_ppp_d;
  logic        ex_reg_write_q, ex_reg_write_d;

  logic [0:5]  id_op;
  logic [0:4]  id_rd;
  logic [0:4]  id_ra;
  logic [0:4]  id_rb;
  logic [0:2]  id_ppp;
  logic [0:1]  id_ww;
  logic [0:5]  id_rins;
  logic        id_alu_ok;

  logic [0:7]  wb_mask;
  logic [0:7]  ex_mask;
  logic        ex_fwd_ok;
  word_t       ra_res;
  word_t       rb_res;

  assign id_op   = if_instr[0:5];
  assign id_rd   = if_instr[6:10];
  assign id_ra   = if_instr[11:15];
  assign id_rb   = if_instr[16:20];
  assign id_ppp  = if_instr[21:23];
  assign id_ww   = if_instr[24:25];
  assign id_rins = if_instr[26:31];

  assign id_alu_ok = (id_op == 6'b101010) && (id_rins >= 6'd1) && (id_rins <= 6'd18);

  // Mask bit i selects byte i (byte 0 = bits [0:7]); reserved codes select nothing.
  function automatic logic [0:7] ppp_mask(input logic [0:2] ppp);
    case (ppp)
      3'b000:  ppp_mask = 8'b1111_1111;
      3'b001:  ppp_mask = 8'b1111_0000;
      3'b010:  ppp_mask = 8'b0000_1111;
      3'b011:  ppp_mask = 8'b1010_1010;
      3'b100:  ppp_mask = 8'b0101_0101;
      default: ppp_mask = 8'b0000_0000;
    endcase
  endfunction

  function automatic word_t merge_bytes(input word_t base, input word_t upd, input logic [0:7] mask);
    word_t r;
    r = base;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) r[8*i +: 8] = upd[8*i +: 8];
    end
    return r;
  endfunction

  assign wb_mask   = ppp_mask(wb_ppp);
  assign ex_mask   = ppp_mask(ex_ppp_q);
  assign ex_fwd_ok = ex_valid_q && ex_reg_write_q;

  // WB bytes are layered over the RF first so that EX bytes win wherever both hit.
  always_comb begin
    ra_res = rf_q[id_ra];
    rb_res = rf_q[id_rb];
    if (wb_en && (wb_addr == id_ra)) ra_res = merge_bytes(ra_res, wb_data, wb_mask);
    if (wb_en && (wb_addr == id_rb)) rb_res = merge_bytes(rb_res, wb_data, wb_mask);
    if (ex_fwd_ok && (ex_rd_q == id_ra)) ra_res = merge_bytes(ra_res, alu_out, ex_mask);
    if (ex_fwd_ok && (ex_rd_q == id_rb)) rb_res = merge_bytes(rb_res, alu_out, ex_mask);
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_addr] = merge_bytes(rf_q[wb_addr], wb_data, wb_mask);
  end

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_ra_val_d    = ex_ra_val_q;
    ex_rb_val_d    = ex_rb_val_q;
    ex_op_code_d   = ex_op_code_q;
    ex_r_ins_d     = ex_r_ins_q;
    ex_ww_d        = ex_ww_q;
    ex_rd_d        = ex_rd_q;
    ex_ppp_d       = ex_ppp_q;
    ex_reg_write_d = ex_reg_write_q;
    if (flush) begin
      ex_valid_d     = 1'b0;
      ex_ra_val_d    = '0;
      ex_rb_val_d    = '0;
      ex_op_code_d   = '0;
      ex_r_ins_d     = '0;
      ex_ww_d        = '0;
      ex_rd_d        = '0;
      ex_ppp_d       = '0;
      ex_reg_write_d = 1'b0;
    end else if (!stall) begin
      ex_valid_d     = if_valid;
      ex_ra_val_d    = ra_res;
      ex_rb_val_d    = rb_res;
      ex_op_code_d   = id_op;
      ex_r_ins_d     = id_rins;
      ex_ww_d        = id_ww;
      ex_rd_d        = id_rd;
      ex_ppp_d       = id_ppp;
      ex_reg_write_d = id_alu_ok && if_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q           <= '{default: '0};
      ex_valid_q     <= 1'b0;
      ex_ra_val_q    <= '0;
      ex_rb_val_q    <= '0;
      ex_op_code_q   <= '0;
      ex_r_ins_q     <= '0;
      ex_ww_q        <= '0;
      ex_rd_q        <= '0;
      ex_ppp_q       <= '0;
      ex_reg_write_q <= 1'b0;
    end else begin
      rf_q           <= rf_d;
      ex_valid_q     <= ex_valid_d;
      ex_ra_val_q    <= ex_ra_val_d;
      ex_rb_val_q    <= ex_rb_val_d;
      ex_op_code_q   <= ex_op_code_d;
      ex_r_ins_q     <= ex_r_ins_d;
      ex_ww_q        <= ex_ww_d;
      ex_rd_q        <= ex_rd_d;
      ex_ppp_q       <= ex_ppp_d;
      ex_reg_write_q <= ex_reg_write_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_rA_val    = ex_ra_val_q;
  assign ex_rB_val    = ex_rb_val_q;
  assign ex_Op_code   = ex_op_code_q;
  assign ex_R_ins     = ex_r_ins_q;
  assign ex_WW        = ex_ww_q;
  assign ex_rD        = ex_rd_q;
  assign ex_ppp       = ex_ppp_q;
  assign ex_reg_write = ex_reg_write_q;

endmodule

// File: doc/vec_id_stage.md
# vec_id_stage

Decode / register-read stage for the 64-bit vector datapath, directly upstream of the ALU. It owns the 32 x 64-bit register file and decodes the 32-bit instruction from IF/ID. It resolves read-after-write hazards by forwarding from the ALU output and the write-back port, with per-byte PPP merge. It then registers the ALU operand bundle (rA_64bit_val, rB_64bit_val, R_ins, Op_code, WW) plus destination info into the ID/EX pipeline register. All vectors are big-endian indexed ([0:63]), and byte 0 is bits [0:7].

## Interface
Parameters:
- NREG, 32, number of 64-bit registers (address width 5).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears register file and ID/EX register.
- stall  in  1  hold ID/EX register; upstream also holds if_instr.
- flush  in  1  load a bubble into ID/EX.
- if_instr  in  [0:31]  instruction: Op_code[0:5], rD[6:10], rA[11:15], rB[16:20], PPP[21:23], WW[24:25], R_ins[26:31].
- if_valid  in  1  if_instr is a real instruction.
- alu_out  in  [0:63]  combinational ALU result of the instruction currently in ID/EX.
- wb_en  in  1  write-back enable.
- wb_addr  in  [0:4]  write-back register.
- wb_ppp  in  [0:2]  write-back byte-participation field.
- wb_data  in  [0:63]  write-back data.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_rA_val, ex_rB_val  out  [0:63]  operand values to the ALU.
- ex_Op_code, ex_R_ins  out  [0:5]  opcode and function code.
- ex_WW  out  [0:1]  operand width.
- ex_rD  out  [0:4]  destination register.
- ex_ppp  out  [0:2]  byte participation.
- ex_reg_write  out  1  instruction writes rD.

## Operation
- Register file: 32 general registers, with no hardwired zero. Write happens on the clk edge when wb_en=1, and only the bytes selected by wb_ppp are written.
- PPP byte-select:
  - 000: all bytes.
  - 001: bytes 0-3.
  - 010: bytes 4-7.
  - 011: even bytes (0, 2, 4, 6).
  - 100: odd bytes.
  - 101-111: no bytes, so the write is suppressed.
- Decode: valid ALU instruction = Op_code 6'b101010 with R_ins in 6'b000001..6'b010010. In that case ex_reg_write=1; otherwise ex_reg_write=0 and all fields still pass through unchanged.
- Operand resolution, applied independently to rA and rB:
  - Start with base = RF[src].
  - WB bypass: if wb_en and wb_addr==src, substitute wb_data into the bytes selected by wb_ppp (write-through).
  - EX forward: if ex_valid, ex_reg_write and ex_rD==src, substitute alu_out into the bytes selected by ex_ppp, on top of the WB-bypassed value.
  - Priority: EX > WB > RF, applied per byte.
- ID/EX capture (each clk edge, in priority order):
  - reset: all outputs become 0.
  - flush: ex_valid=0, ex_reg_write=0, all other fields 0.
  - stall: all ex_* hold.
  - otherwise: capture decoded fields and resolved operands; ex_valid=if_valid; ex_reg_write = decode result AND if_valid.
- The write-back port is independent of stall and flush: RF writes always occur when wb_en=1.
- The register file is not part of the ALU-visible state. Unused operands (rB for VNOT, VMOV, VSQEU, VSQOU, VSQRT) are still read and forwarded; no special casing.

## Timing
- Latency: 1 cycle. if_instr at edge N appears on ex_* after edge N+1.
- Reset: every ex_* output 0 and all 32 registers 0 in the cycle after reset is sampled. Reset mid-stall or mid-flush wins over both.
- Same-cycle WB write and ID read of the same register: ID sees the merged new value (bypass); the RF holds it from the next cycle.
- Same-cycle EX and WB hits on the same register: per byte, EX bytes override WB bytes, which override RF bytes.
- flush and stall both high: flush wins and a bubble is loaded.
- stall for k cycles: ex_* are held constant for k cycles. EX forwarding during stall compares against the held ID/EX contents; upstream must re-present the same if_instr.
- A wb_ppp or ex_ppp in 101-111 contributes no bytes (no forward, no write).

## Test plan
- Reset: hold reset 2 cycles -> all ex_* = 0; then present VAND reading r5 with no writes -> ex_rA_val = 64'h0.
- RF write/read: wb writes r3 = 64'h01234567_89ABCDEF with PPP 000. The next cycle issue VADD (R_ins 000110, WW 10) rD=4, rA=3, rB=3 -> one cycle later ex_rA_val = ex_rB_val = 64'h01234567_89ABCDEF and ex_reg_write=1.
- WB bypass, partial: r7 = 0. In the same cycle wb writes r7 = 64'hFFFFFFFF_FFFFFFFF with PPP 010 while ID reads rA=7 -> ex_rA_val = 64'h00000000_FFFFFFFF; a later read of r7 returns the same value.
- EX forward with merge: r2 = 64'h11111111_11111111. VOR rD=2 with PPP 011 sits in ID/EX with alu_out = 64'hAAAAAAAA_AAAAAAAA, while ID reads rB=2 -> ex_rB_val = 64'hAA11AA11_AA11AA11. Repeat with a simultaneous wb to r2 of 64'h22222222_22222222 (PPP 000) -> 64'hAA22AA22_AA22AA22.
- Stall/flush: stall 3 cycles with if_instr changing -> ex_* unchanged. Assert stall and flush together -> ex_valid=0, ex_reg_write=0 next cycle. A wb during the stall still updates the RF.
- Non-ALU decode: Op_code 6'b000000 (and separately Op_code 101010 with R_ins 6'b010011) with if_valid=1 -> ex_valid=1, ex_reg_write=0. A following reader of that rD is not forwarded alu_out.
